// File: rtl/alu_issue_pkg.sv
// rtl/alu_issue_pkg.sv - shared types, instruction field layout and decode helpers for alu_issue_seq
package alu_issue_pkg;

  // Register file addressing and instruction width
  localparam int REG_AW  = 2;
  localparam int INSTR_W = 8;

  // Instruction field bit positions: [7:6] op, [5:4] rd, [3:2] rs, [1] cmp, [0] reserved
  localparam int OP_MSB  = 7;
  localparam int OP_LSB  = 6;
  localparam int RD_MSB  = 5;
  localparam int RD_LSB  = 4;
  localparam int RS_MSB  = 3;
  localparam int RS_LSB  = 2;
  localparam int CMP_BIT = 1;
  localparam int RSV_BIT = 0;

  // ALU operation encoding, passed to the ALU unmodified
  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_OR  = 2'b10,
    OP_AND = 2'b11
  } alu_op_t;

  // Sequencer states; 2'b11 is unused and recovers to IDLE
  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_EXEC = 2'b01,
    ST_WB   = 2'b10
  } seq_state_t;

  function automatic alu_op_t instr_op(input logic [INSTR_W-1:0] instr);
    return alu_op_t'(instr[OP_MSB:OP_LSB]);
  endfunction

  function automatic logic [REG_AW-1:0] instr_rd(input logic [INSTR_W-1:0] instr);
    return instr[RD_MSB:RD_LSB];
  endfunction

  function automatic logic [REG_AW-1:0] instr_rs(input logic [INSTR_W-1:0] instr);
    return instr[RS_MSB:RS_LSB];
  endfunction

endpackage

// File: rtl/alu_issue_regfile.sv
// rtl/alu_issue_regfile.sv - NREGS x W operand register file, two operand read ports, one debug read port, one write port
module alu_issue_regfile
  import alu_issue_pkg::*;
#(
  parameter int NREGS = 4,
  parameter int W     = 8
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_we,
  input  logic [REG_AW-1:0] i_waddr,
  input  logic [W-1:0]      i_wdata,
  input  logic [REG_AW-1:0] i_ra_addr,
  output logic [W-1:0]      o_ra_data,
  input  logic [REG_AW-1:0] i_rb_addr,
  output logic [W-1:0]      o_rb_data,
  input  logic [REG_AW-1:0] i_dbg_addr,
  output logic [W-1:0]      o_dbg_data
);

  logic [W-1:0] r_regs [NREGS];

  // Storage: cleared on reset, single write port selected by the parent
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int i = 0; i < NREGS; i++) begin
        r_regs[i] <= '0;
      end
    end else if (i_we) begin
      r_regs[i_waddr] <= i_wdata;
    end
  end

  // Read ports are combinational; a write becomes visible only after its edge
  assign o_ra_data  = r_regs[i_ra_addr];
  assign o_rb_data  = r_regs[i_rb_addr];
  assign o_dbg_data = r_regs[i_dbg_addr];

endmodule

// File: rtl/alu_issue_seq.sv
// rtl/alu_issue_seq.sv - issue sequencer feeding the 8-bit ALU; optional compare via ALU_ISSUE_SEQ_CMP_EN
module alu_issue_seq
  import alu_issue_pkg::*;
#(
  parameter int NREGS = 4,
  parameter int W     = 8
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_instr_valid,
  output logic               o_instr_ready,
  input  logic [INSTR_W-1:0] i_instr,
  input  logic               i_ld_valid,
  output logic               o_ld_ready,
  input  logic [REG_AW-1:0]  i_ld_addr,
  input  logic [W-1:0]       i_ld_data,
  output logic               o_alu_en,
  output logic [1:0]         o_alu_op,
  output logic [W-1:0]       o_alu_a,
  output logic [W-1:0]       o_alu_b,
  input  logic [W-1:0]       i_alu_out,
  input  logic               i_alu_f_z,
  input  logic               i_alu_f_c,
  output logic               o_z_flag,
  output logic               o_c_flag,
  output logic               o_wb_done,
  input  logic [REG_AW-1:0]  i_dbg_addr,
  output logic [W-1:0]       o_dbg_data
);

  seq_state_t        r_state;
  seq_state_t        w_next_state;

  logic              w_instr_ready;
  logic              w_ld_ready;
  logic              w_alu_en;
  logic              w_wb_done;

  logic              w_accept;
  logic              w_ld_fire;
  logic              w_wb_write;

  logic [W-1:0]      w_rd_data;
  logic [W-1:0]      w_rs_data;

  logic              w_we;
  logic [REG_AW-1:0] w_waddr;
  logic [W-1:0]      w_wdata;

  logic [W-1:0]      r_alu_a;
  logic [W-1:0]      r_alu_b;
  alu_op_t           r_alu_op;
  logic [REG_AW-1:0] r_rd;
  logic              r_z_flag;
  logic              r_c_flag;

  // Instruction has priority over a load in IDLE, so a load never fires on an accept edge
  assign w_accept  = (r_state == ST_IDLE) && i_instr_valid;
  assign w_ld_fire = i_ld_valid && w_ld_ready;

`ifdef ALU_ISSUE_SEQ_CMP_EN
  logic r_cmp;
  logic w_unused_instr_bits;

  // Compare flag captured with the instruction; a compare updates flags only
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_cmp <= 1'b0;
    end else if (w_accept) begin
      r_cmp <= i_instr[CMP_BIT];
    end
  end

  assign w_wb_write          = !r_cmp;
  assign w_unused_instr_bits = i_instr[RSV_BIT];
`else
  logic w_unused_instr_bits;

  assign w_wb_write          = 1'b1;
  assign w_unused_instr_bits = ^{i_instr[CMP_BIT], i_instr[RSV_BIT]};
`endif

  // State register; reset aborts any in-flight instruction
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next state: IDLE -> EXEC -> WB -> IDLE, one instruction per three cycles
  always_comb begin
    w_next_state = ST_IDLE;
    case (r_state)
      ST_IDLE: w_next_state = i_instr_valid ? ST_EXEC : ST_IDLE;
      ST_EXEC: w_next_state = ST_WB;
      ST_WB:   w_next_state = ST_IDLE;
      default: w_next_state = ST_IDLE;
    endcase
  end

  // FSM outputs; ld_ready is masked during reset because the state already reads IDLE then
  always_comb begin
    w_instr_ready = 1'b0;
    w_ld_ready    = 1'b0;
    w_alu_en      = 1'b0;
    w_wb_done     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_instr_ready = 1'b1;
        w_ld_ready    = !i_instr_valid && !i_rst;
      end
      ST_EXEC: w_alu_en  = 1'b1;
      ST_WB:   w_wb_done = 1'b1;
      default: w_instr_ready = 1'b0;
    endcase
  end

  // Operand, op and destination capture at accept; held through EXEC and WB
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_alu_a  <= '0;
      r_alu_b  <= '0;
      r_alu_op <= OP_ADD;
      r_rd     <= '0;
    end else if (w_accept) begin
      r_alu_a  <= w_rd_data;
      r_alu_b  <= w_rs_data;
      r_alu_op <= instr_op(i_instr);
      r_rd     <= instr_rd(i_instr);
    end
  end

  // Architectural flags follow the ALU verbatim at the WB closing edge
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_z_flag <= 1'b0;
      r_c_flag <= 1'b0;
    end else if (r_state == ST_WB) begin
      r_z_flag <= i_alu_f_z;
      r_c_flag <= i_alu_f_c;
    end
  end

  // Write port mux: WB and load occupy disjoint states so they never collide
  always_comb begin
    w_we    = 1'b0;
    w_waddr = i_ld_addr;
    w_wdata = i_ld_data;
    if (r_state == ST_WB) begin
      w_we    = w_wb_write;
      w_waddr = r_rd;
      w_wdata = i_alu_out;
    end else if (w_ld_fire) begin
      w_we    = 1'b1;
    end
  end

  alu_issue_regfile #(
    .NREGS (NREGS),
    .W     (W)
  ) u_regfile (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_we       (w_we),
    .i_waddr    (w_waddr),
    .i_wdata    (w_wdata),
    .i_ra_addr  (instr_rd(i_instr)),
    .o_ra_data  (w_rd_data),
    .i_rb_addr  (instr_rs(i_instr)),
    .o_rb_data  (w_rs_data),
    .i_dbg_addr (i_dbg_addr),
    .o_dbg_data (o_dbg_data)
  );

  assign o_instr_ready = w_instr_ready;
  assign o_ld_ready    = w_ld_ready;
  assign o_alu_en      = w_alu_en;
  assign o_wb_done     = w_wb_done;
  assign o_alu_a       = r_alu_a;
  assign o_alu_b       = r_alu_b;
  assign o_alu_op      = r_alu_op;
  assign o_z_flag      = r_z_flag;
  assign o_c_flag      = r_c_flag;

endmodule
